// File: rtl/spi_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_master
//  Description : SPI mode-0 controller issuing 16-bit {opcode, payload}
//                command frames MSB first, capturing the 16-bit reply on
//                cipo, with a mandatory commit pulse and a cs-high gap.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [11:0] req_payload,
    output logic        sclk,
    output logic        cs,
    output logic        copi,
    input  logic        cipo,
    output logic [15:0] rsp_data,
    output logic        done,
    output logic        err
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_HALVES - 1);
    localparam logic [4:0]       C_BIT_COMMIT = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_bit;
    logic [GAP_W-1:0] r_gap;
    logic [15:0]      r_tx;
    logic [15:0]      r_rx;

    logic w_div_wrap;
    logic w_accept;
    logic w_op_ok;

    assign w_div_wrap = (r_div == C_DIV_LAST);
    assign w_accept   = req_valid && req_ready;
    assign w_op_ok    = (req_opcode >= 4'd1) && (req_opcode <= 4'd3);

    // Frame sequencer: every phase lasts one sclk half-period (CLK_DIV clocks),
    // so a single wrapping divider paces SETUP, each sclk half, HOLD and GAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            sclk      <= 1'b0;
            cs        <= 1'b1;
            copi      <= 1'b0;
            rsp_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_div     <= '0;
                    req_ready <= 1'b1;
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        if (w_op_ok) begin
                            r_state <= ST_SETUP;
                            r_tx    <= {req_opcode, req_payload};
                            r_rx    <= '0;
                            r_bit   <= '0;
                            cs      <= 1'b0;
                            copi    <= req_opcode[3];
                        end else begin
                            // Illegal opcodes never reach the wire.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end

                ST_SETUP: begin
                    if (w_div_wrap) begin
                        sclk    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_div_wrap) begin
                        if (sclk) begin
                            // Falling edge: capture the reply bit and present the next data bit.
                            sclk  <= 1'b0;
                            r_rx  <= {r_rx[14:0], cipo};
                            r_tx  <= {r_tx[14:0], 1'b0};
                            copi  <= r_tx[14];
                            r_bit <= r_bit + 5'd1;
                        end else begin
                            sclk <= 1'b1;
                            if (r_bit == C_BIT_COMMIT) begin
                                r_state <= ST_COMMIT;
                            end
                        end
                    end
                end

                ST_COMMIT: begin
                    // The responder dispatches on this extra rising edge; copi is already 0.
                    if (w_div_wrap) begin
                        if (sclk) begin
                            sclk <= 1'b0;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (w_div_wrap) begin
                        cs       <= 1'b1;
                        done     <= 1'b1;
                        rsp_data <= r_rx;
                        r_gap    <= '0;
                        r_state  <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (w_div_wrap) begin
                        if (r_gap == C_GAP_LAST) begin
                            r_state   <= ST_IDLE;
                            req_ready <= 1'b1;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
